ysyx_22040237_wbu: RTL and testbench
====================================

# ysyx_22040237_wbu

Writeback unit and architectural register file for the ysyx_22040237 RV64 core, placed directly downstream of the load/store unit. It accepts the LSU's (rd_wr_en, rd_idx, rd_data) triple through a valid/ready handshake into a one-entry writeback register, then commits it to a 32 x XLEN register file on the following cycle unless held. It also serves the two decode-stage source-register read ports and counts retired instructions.

## Interface
- XLEN, default 64: register and data width; matches `ysyx_22040237_REG_WIDTH`.
- NREG, default 32: number of architectural registers; index width is fixed at 5.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  LSU result valid.
- in_ready_o  out  1  WBU can accept a result this cycle.
- rd_wr_en_i  in  1  result writes a register.
- rd_idx_i  in  5  destination register index.
- rd_data_i  in  XLEN  destination data.
- hold_i  in  1  blocks commit of the staged entry, e.g. for a debug halt.
- rs1_idx_i  in  5  read port 1 index.
- rs2_idx_i  in  5  read port 2 index.
- rs1_data_o  out  XLEN  read port 1 data.
- rs2_data_o  out  XLEN  read port 2 data.
- raw_hazard_o  out  1  a read port targets the staged, uncommitted rd.
- commit_o  out  1  staged entry commits at the next edge.
- retire_cnt_o  out  64  retired-instruction count.

## Operation
- Staging register: fields wb_valid_q, wb_wen_q, wb_idx_q and wb_data_q.
- in_ready_o = !wb_valid_q || commit_o. This is combinational.
- commit_o = wb_valid_q && !hold_i.
- Accept occurs when in_valid_i && in_ready_o. At the edge, the staging register loads the inputs and wb_valid_q is set to 1.
- Commit occurs when commit_o is high:
  - At the edge, if wb_wen_q && wb_idx_q != 0, then regfile[wb_idx_q] <= wb_data_q.
  - retire_cnt_o increments by 1.
  - wb_valid_q clears, unless a new accept happens at the same edge.
- Simultaneous accept and commit: the old entry commits and the new entry is staged at the same edge. This gives full throughput of 1 per cycle.
- x0 handling:
  - A write to x0 is discarded but still counts as retired.
  - Reading x0 always returns 0.
- Reads are combinational: rsN_data_o = regfile[rsN_idx_i], or 0 for x0.
- raw_hazard_o = wb_valid_q && wb_wen_q && wb_idx_q != 0 && (wb_idx_q == rs1_idx_i || wb_idx_q == rs2_idx_i).
- retire_cnt_o wraps from 2^64-1 to 0.
- hold_i only blocks commit; a held entry stays staged unchanged.

## Timing
- Reset values: all regfile entries 0, wb_valid_q 0, retire_cnt_o 0, commit_o 0, in_ready_o 1, raw_hazard_o 0, read data 0.
- Reset asserted mid-operation discards the staged entry immediately; no commit occurs.
- Latency: a result accepted at edge N becomes architecturally visible in the regfile after edge N+1 when hold_i is low, or after the first edge at which hold_i is low.
- Write-then-read to the same index in the same cycle as the commit edge: the read port returns the old value before the edge and the new value after it. The regfile has no internal write-through.

## Configuration
- YSYX_22040237_WB_BYPASS_EN defined:
  - A read port whose index matches the staged entry (wb_valid_q && wb_wen_q && idx != 0) returns wb_data_q.
  - raw_hazard_o is tied 0.
- YSYX_22040237_WB_BYPASS_EN undefined:
  - Reads return regfile contents only.
  - raw_hazard_o is driven as defined above, and the upstream stage must stall on it.

## Test plan
- Reset then read: deassert rst and read x1..x31 -> all read 0; retire_cnt_o = 0; in_ready_o = 1.
- Basic writeback: accept (wen=1, idx=5, data=0xDEADBEEF_CAFEF00D) -> commit_o = 1 the next cycle; after that edge x5 reads 0xDEADBEEF_CAFEF00D and retire_cnt_o = 1.
- x0 write: accept (wen=1, idx=0, data=0x1234) -> x0 still reads 0; retire_cnt_o increments by 1.
- Back-to-back with hold:
  - Stream idx 1, 2, 3 on consecutive cycles with data 0x11, 0x22, 0x33.
  - Assert hold_i for 3 cycles while idx 2 is staged -> in_ready_o = 0 during the hold and the idx 3 input is held by the source.
  - Final state: x1=0x11, x2=0x22, x3=0x33; retire_cnt_o = 3.
- Hazard and bypass: stage (idx=7, data=0x77) with rs1_idx_i = 7 and hold_i = 1 -> with the bypass macro, rs1_data_o = 0x77 and raw_hazard_o = 0; without the macro, rs1_data_o = the old x7 value and raw_hazard_o = 1.
- Reset mid-operation: stage (idx=9, data=0x99), then assert rst before commit -> x9 = 0, retire_cnt_o = 0, wb_valid_q = 0.

Source files
------------

// File: rtl/ysyx_22040237_wbu.sv
// Writeback unit: one-entry staging register in front of a 32 x XLEN register file,
// two combinational read ports and a retired-instruction counter.
// Optional feature macro: YSYX_22040237_WB_BYPASS_EN (forward the staged entry to the read ports).
module ysyx_22040237_wbu #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              rd_wr_en_i,
  input  logic [4:0]        rd_idx_i,
  input  logic [XLEN-1:0]   rd_data_i,
  input  logic              hold_i,
  input  logic [4:0]        rs1_idx_i,
  input  logic [4:0]        rs2_idx_i,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  output logic              raw_hazard_o,
  output logic              commit_o,
  output logic [63:0]       retire_cnt_o
);

  localparam int unsigned IDX_W = 5;
  localparam int unsigned CNT_W = 64;

  logic              wb_valid_q, wb_valid_d;
  logic              wb_wen_q,   wb_wen_d;
  logic [IDX_W-1:0]  wb_idx_q,   wb_idx_d;
  logic [XLEN-1:0]   wb_data_q,  wb_data_d;
  logic [CNT_W-1:0]  retire_q,   retire_d;
  logic [XLEN-1:0]   rf_q [NREG];

  logic              accept;
  logic              stage_wr;
  logic [IDX_W-1:0]  rs_idx  [2];
  logic [XLEN-1:0]   rs_data [2];

  assign commit_o     = wb_valid_q && !hold_i;
  assign in_ready_o   = !wb_valid_q || commit_o;
  assign accept       = in_valid_i && in_ready_o;
  // Staged entry will really change a register (x0 writes are dropped)
  assign stage_wr     = wb_valid_q && wb_wen_q && (wb_idx_q != '0);
  assign retire_cnt_o = retire_q;

  // Next state of staging register and retire counter; accept wins over commit-clear
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_wen_d   = wb_wen_q;
    wb_idx_d   = wb_idx_q;
    wb_data_d  = wb_data_q;
    retire_d   = retire_q;
    if (commit_o) begin
      wb_valid_d = 1'b0;
      retire_d   = retire_q + CNT_W'(1);
    end
    if (accept) begin
      wb_valid_d = 1'b1;
      wb_wen_d   = rd_wr_en_i;
      wb_idx_d   = rd_idx_i;
      wb_data_d  = rd_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_q <= 1'b0;
      wb_wen_q   <= 1'b0;
      wb_idx_q   <= '0;
      wb_data_q  <= '0;
      retire_q   <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_wen_q   <= wb_wen_d;
      wb_idx_q   <= wb_idx_d;
      wb_data_q  <= wb_data_d;
      retire_q   <= retire_d;
    end
  end

  // Architectural register file; no write-through to the read ports
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
    end else if (commit_o && stage_wr) begin
      rf_q[wb_idx_q] <= wb_data_q;
    end
  end

  assign rs_idx[0]  = rs1_idx_i;
  assign rs_idx[1]  = rs2_idx_i;
  assign rs1_data_o = rs_data[0];
  assign rs2_data_o = rs_data[1];

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rs_data[p] = '0;
      if (rs_idx[p] != '0) rs_data[p] = rf_q[rs_idx[p]];
`ifdef YSYX_22040237_WB_BYPASS_EN
      if (stage_wr && (wb_idx_q == rs_idx[p])) rs_data[p] = wb_data_q;
`endif
    end
  end

`ifdef YSYX_22040237_WB_BYPASS_EN
  assign raw_hazard_o = 1'b0;
`else
  // Consumer must stall until the staged write lands in the regfile
  assign raw_hazard_o = stage_wr && ((wb_idx_q == rs1_idx_i) || (wb_idx_q == rs2_idx_i));
`endif

endmodule

// File: tb/tb_ysyx_22040237_wbu.sv
// Self-checking bench for ysyx_22040237_wbu: a queue-based reference model of the
// staged results and register file, checked every cycle against the DUT outputs.
module tb_ysyx_22040237_wbu;

  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid_i, in_ready_o, rd_wr_en_i, hold_i;
  logic [4:0]      rd_idx_i, rs1_idx_i, rs2_idx_i;
  logic [XLEN-1:0] rd_data_i, rs1_data_o, rs2_data_o;
  logic            raw_hazard_o, commit_o;
  logic [63:0]     retire_cnt_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic            wen;
    logic [4:0]      idx;
    logic [XLEN-1:0] data;
  } wb_item_t;

  wb_item_t        exp_q[$];
  logic [XLEN-1:0] m_regs [32];
  logic [63:0]     m_cnt;

  ysyx_22040237_wbu #(.XLEN(XLEN), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .rd_wr_en_i(rd_wr_en_i), .rd_idx_i(rd_idx_i), .rd_data_i(rd_data_i),
    .hold_i(hold_i),
    .rs1_idx_i(rs1_idx_i), .rs2_idx_i(rs2_idx_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .raw_hazard_o(raw_hazard_o), .commit_o(commit_o),
    .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural view of a read port as the rules define it
  function automatic logic [XLEN-1:0] model_read(input logic [4:0] idx);
    logic [XLEN-1:0] v;
    v = (idx == 5'd0) ? '0 : m_regs[idx];
`ifdef YSYX_22040237_WB_BYPASS_EN
    if (exp_q.size() != 0 && exp_q[0].wen && exp_q[0].idx == idx && idx != 5'd0) v = exp_q[0].data;
`endif
    return v;
  endfunction

  function automatic logic model_hazard();
`ifdef YSYX_22040237_WB_BYPASS_EN
    return 1'b0;
`else
    if (exp_q.size() == 0) return 1'b0;
    return exp_q[0].wen && exp_q[0].idx != 5'd0 &&
           (exp_q[0].idx == rs1_idx_i || exp_q[0].idx == rs2_idx_i);
`endif
  endfunction

  // Reference model: commit pops the head, accept pushes the offered result
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_cnt = '0;
    end else begin
      logic ready, commit;
      wb_item_t it;
      commit = (exp_q.size() != 0) && !hold_i;
      ready  = (exp_q.size() == 0) || !hold_i;
      if (commit) begin
        it = exp_q.pop_front();
        if (it.wen && it.idx != 5'd0) m_regs[it.idx] = it.data;
        m_cnt = m_cnt + 64'd1;
      end
      if (in_valid_i && ready) begin
        it.wen = rd_wr_en_i; it.idx = rd_idx_i; it.data = rd_data_i;
        exp_q.push_back(it);
      end
    end
  end

  // Monitor: compare every observable output mid-cycle
  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready_o), 64'((exp_q.size() == 0) || !hold_i));
    chk("commit",   64'(commit_o),   64'((exp_q.size() != 0) && !hold_i));
    chk("hazard",   64'(raw_hazard_o), 64'(model_hazard()));
    chk("rs1_data", rs1_data_o, model_read(rs1_idx_i));
    chk("rs2_data", rs2_data_o, model_read(rs2_idx_i));
    chk("retire",   retire_cnt_o, m_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic wen, input logic [4:0] idx, input logic [XLEN-1:0] data);
    in_valid_i = 1'b1; rd_wr_en_i = wen; rd_idx_i = idx; rd_data_i = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] base;
    logic acc;
    rst = 1'b0; in_valid_i = 1'b0; rd_wr_en_i = 1'b0; rd_idx_i = '0; rd_data_i = '0;
    hold_i = 1'b0; rs1_idx_i = '0; rs2_idx_i = '0;
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // All registers read zero after reset
    for (int i = 1; i < 32; i++) begin
      rs1_idx_i = 5'(i); rs2_idx_i = 5'(32 - i);
      @(negedge clk);
      chk("reset_read", rs1_data_o, 64'd0);
      tick();
    end
    chk("reset_ready", 64'(in_ready_o), 64'd1);

    // Basic writeback to x5
    rs1_idx_i = 5'd5;
    offer(1'b1, 5'd5, 64'hDEADBEEF_CAFEF00D);
    tick();
    in_valid_i = 1'b0;
    @(negedge clk);
    chk("basic_commit", 64'(commit_o), 64'd1);
    tick();
    @(negedge clk);
    chk("basic_x5", rs1_data_o, 64'hDEADBEEF_CAFEF00D);
    chk("basic_cnt", retire_cnt_o, 64'd1);

    // Write to x0 is dropped but retires
    tick();
    rs1_idx_i = 5'd0;
    offer(1'b1, 5'd0, 64'h1234);
    tick();
    in_valid_i = 1'b0;
    tick();
    @(negedge clk);
    chk("x0_read", rs1_data_o, 64'd0);
    chk("x0_cnt", retire_cnt_o, 64'd2);

    // Back-to-back stream with a 3-cycle hold while idx 2 is staged
    tick();
    base = retire_cnt_o;
    offer(1'b1, 5'd1, 64'h11); tick();
    offer(1'b1, 5'd2, 64'h22); tick();
    offer(1'b1, 5'd3, 64'h33); hold_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_ready", 64'(in_ready_o), 64'd0);
      tick();
    end
    hold_i = 1'b0; tick();
    in_valid_i = 1'b0; tick();
    rs1_idx_i = 5'd1; rs2_idx_i = 5'd2;
    @(negedge clk);
    chk("b2b_x1", rs1_data_o, 64'h11);
    chk("b2b_x2", rs2_data_o, 64'h22);
    tick();
    rs1_idx_i = 5'd3;
    @(negedge clk);
    chk("b2b_x3", rs1_data_o, 64'h33);
    chk("b2b_cnt", retire_cnt_o - base, 64'd3);

    // Staged x7 with hold: bypass or hazard
    tick();
    rs1_idx_i = 5'd7; rs2_idx_i = 5'd0; hold_i = 1'b1;
    offer(1'b1, 5'd7, 64'h77);
    tick();
    in_valid_i = 1'b0;
    @(negedge clk);
`ifdef YSYX_22040237_WB_BYPASS_EN
    chk("byp_data", rs1_data_o, 64'h77);
    chk("byp_hazard", 64'(raw_hazard_o), 64'd0);
`else
    chk("haz_data", rs1_data_o, 64'd0);
    chk("haz_flag", 64'(raw_hazard_o), 64'd1);
`endif
    tick();
    hold_i = 1'b0;
    tick(); tick();

    // Reset while x9 is staged discards it
    rs1_idx_i = 5'd9; hold_i = 1'b1;
    offer(1'b1, 5'd9, 64'h99);
    tick();
    in_valid_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_cnt", retire_cnt_o, 64'd0);
    chk("rst_commit", 64'(commit_o), 64'd0);
    tick();
    rst = 1'b1; hold_i = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_x9", rs1_data_o, 64'd0);
    chk("rst_cnt_after", retire_cnt_o, 64'd0);
    tick();

    // Randomized traffic with random holds; source keeps its offer until accepted
    for (int c = 0; c < 600; c++) begin
      hold_i    = ($urandom_range(0, 3) == 0);
      rs1_idx_i = 5'($urandom_range(0, 7));
      rs2_idx_i = 5'($urandom_range(0, 31));
      @(negedge clk);
      acc = in_valid_i && in_ready_o;
      tick();
      if (!in_valid_i || acc) begin
        if ($urandom_range(0, 3) != 0)
          offer(1'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)), {$urandom, $urandom});
        else
          in_valid_i = 1'b0;
      end
    end
    in_valid_i = 1'b0; hold_i = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
